// File: rtl/rf_pkg.sv
// Shared defaults and the per-byte write-merge helper for the multi-port register file.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 3;
  localparam int NUM_WR_DEF = 2;
  localparam int BYTES      = DATA_W_DEF / 8;
  // Upper bound on write ports accepted by merge_byte; unused lanes are tied to zero.
  localparam int MAX_WR     = 8;

  // Pick the byte from the highest-index hitting port, else keep the old byte.
  function automatic logic [7:0] merge_byte(
    input logic [7:0]          old_byte,
    input logic [MAX_WR-1:0]   hit,
    input logic [MAX_WR*8-1:0] cand
  );
    logic [7:0] res;
    res = old_byte;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) begin
        res = cand[i*8 +: 8];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: set-over-clear priority, clear bypass onto busy, registered popcount.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0]        wr_clr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] set_v;
  logic [DEPTH-1:0] clr_v;
  logic [DEPTH-1:0] next_pend;
  logic [ADDR_W:0]  next_cnt;

  // Decode issue/clear events and form the next pending vector and its count.
  always_comb begin
    set_v    = '0;
    clr_v    = '0;
    next_cnt = '0;
    if (iss_en) begin
      set_v[iss_addr] = 1'b1;
    end else begin
      set_v = '0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && wr_clr[p]) begin
        clr_v[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
      end else begin
        clr_v = clr_v;
      end
    end
    if (ZERO_REG) begin
      set_v[0] = 1'b0;
      clr_v[0] = 1'b0;
    end else begin
      set_v = set_v;
    end
    next_pend = set_v | (pending & ~clr_v);
    for (int a = 0; a < DEPTH; a++) begin
      next_cnt = next_cnt + (ADDR_W+1)'(next_pend[a]);
    end
  end

  // A lone clear reads through as not-busy; a same-cycle issue only shows next cycle.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = pending[rd_addr[k*ADDR_W +: ADDR_W]] &
                   ~(clr_v[rd_addr[k*ADDR_W +: ADDR_W]] & ~set_v[rd_addr[k*ADDR_W +: ADDR_W]]);
    end
  end

  // Pending state and its count update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= next_pend;
      pend_cnt <= next_cnt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port byte-enabled register file with write-first read bypass and pending scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]       rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]       wr_data,
  input  logic [NUM_WR*(DATA_W/8)-1:0]   wr_be,
  input  logic [NUM_WR-1:0]              wr_clr,
  input  logic                           iss_en,
  input  logic [ADDR_W-1:0]              iss_addr,
  output logic [ADDR_W:0]                pend_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] next_mem [DEPTH];

  // Next array image; it doubles as the bypass source so update and read agree by construction.
  always_comb begin
    logic [MAX_WR-1:0]   hit;
    logic [MAX_WR*8-1:0] cand;
    hit  = '0;
    cand = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int b = 0; b < NB; b++) begin
        hit  = '0;
        cand = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          hit[p]          = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(a)) && wr_be[p*NB + b];
          cand[p*8 +: 8]  = wr_data[p*DATA_W + b*8 +: 8];
        end
        next_mem[a][b*8 +: 8] = merge_byte(mem[a][b*8 +: 8], hit, cand);
      end
    end
    if (ZERO_REG) begin
      next_mem[0] = '0;
    end else begin
      next_mem[0] = next_mem[0];
    end
  end

  // Reads see the post-write value; held at zero while reset discards the cycle's writes.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rst) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = next_mem[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Data array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= next_mem[a];
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector-table bench for regfile_mp with hand-computed expectations.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [1:0]  wr_clr;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [5:0]  pend_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  be0, be1;
    logic [1:0]  clr;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t vecs[17];

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0, input logic [3:0] be0,
    input logic [4:0] wa1, input logic [31:0] wd1, input logic [3:0] be1, input logic [1:0] clr,
    input logic ie, input logic [4:0] ia,
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
    input logic [2:0] eb, input logic [5:0] ec
  );
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.be0 = be0;
    v.wa1 = wa1; v.wd1 = wd1; v.be1 = be1; v.clr = clr;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; wr_be = '0; wr_clr = 2'b00;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  initial begin
    vec_t v;
    // we  wa0 wd0            be0    wa1 wd1            be1    clr    ie    ia   ra0 ra1 ra2  e0 e1 e2  eb  ec
    vecs[0]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5,
                  32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
    vecs[1]  = mk(2'b01, 5'd3, 32'hAABBCCDD, 4'hF, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd3, 5'd3, 5'd5,
                  32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 3'b000, 6'd0);
    vecs[2]  = mk(2'b10, 5'd0, 32'h0, 4'h0, 5'd3, 32'h11223344, 4'h3, 2'b00, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3,
                  32'hAABB3344, 32'h0, 32'hAABB3344, 3'b000, 6'd0);
    vecs[3]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3,
                  32'hAABB3344, 32'hAABB3344, 32'hAABB3344, 3'b000, 6'd0);
    vecs[4]  = mk(2'b11, 5'd7, 32'h11111111, 4'hF, 5'd7, 32'h22222222, 4'h5, 2'b00, 1'b0, 5'd0, 5'd7, 5'd7, 5'd3,
                  32'h11221122, 32'h11221122, 32'hAABB3344, 3'b000, 6'd0);
    vecs[5]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7,
                  32'h11221122, 32'h11221122, 32'h11221122, 3'b000, 6'd0);
    vecs[6]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b1, 5'd9, 5'd9, 5'd9, 5'd7,
                  32'h0, 32'h0, 32'h11221122, 3'b000, 6'd0);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b111, 6'd1);
    vecs[8]  = mk(2'b01, 5'd9, 32'hDEADBEEF, 4'h0, 5'd0, 32'h0, 4'h0, 2'b01, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b000, 6'd1);
    vecs[9]  = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
    vecs[10] = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
    vecs[11] = mk(2'b10, 5'd0, 32'h0, 4'h0, 5'd9, 32'h0, 4'h0, 2'b10, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b111, 6'd1);
    vecs[12] = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b111, 6'd1);
    vecs[13] = mk(2'b01, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 32'h0, 4'h0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 5'd9,
                  32'h0, 32'h0, 32'h0, 3'b100, 6'd1);
    vecs[14] = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd9, 5'd3,
                  32'h0, 32'h0, 32'hAABB3344, 3'b010, 6'd1);
    vecs[15] = mk(2'b01, 5'd9, 32'h000000EE, 4'h1, 5'd0, 32'h0, 4'h0, 2'b01, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h000000EE, 32'h000000EE, 32'h000000EE, 3'b000, 6'd1);
    vecs[16] = mk(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9,
                  32'h000000EE, 32'h000000EE, 32'h000000EE, 3'b000, 6'd0);

    rst = 1'b1;
    idle();
    rd_addr = {5'd5, 5'd5, 5'd5};
    repeat (2) @(posedge clk);
    #2;
    chk("reset_data0", -1, rd_data[31:0], 32'h0);
    chk("reset_cnt", -1, {26'd0, pend_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      v = vecs[i];
      wr_en = v.we; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
      wr_be = {v.be1, v.be0}; wr_clr = v.clr; iss_en = v.ie; iss_addr = v.ia;
      rd_addr = {v.ra2, v.ra1, v.ra0};
      #2;
      chk("rd_data0", i, rd_data[31:0], v.e0);
      chk("rd_data1", i, rd_data[63:32], v.e1);
      chk("rd_data2", i, rd_data[95:64], v.e2);
      chk("rd_busy", i, {29'd0, rd_busy}, {29'd0, v.eb});
      chk("pend_cnt", i, {26'd0, pend_cnt}, {26'd0, v.ec});
      @(posedge clk);
      #1;
    end

    // Issue r1..r4, then reset in the middle of a write to r10.
    idle();
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      @(posedge clk);
      #1;
    end
    idle();
    rd_addr = {5'd10, 5'd1, 5'd10};
    #1;
    chk("cnt_after_issue", 100, {26'd0, pend_cnt}, 32'd4);
    chk("busy_r1", 100, {31'd0, rd_busy[1]}, 32'd1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'hCAFEBABE}; wr_be = 8'h0F;
    #1;
    chk("bypass_r10", 101, rd_data[31:0], 32'hCAFEBABE);
    rst = 1'b1;
    #1;
    chk("rst_data_r10", 102, rd_data[31:0], 32'h0);
    chk("rst_busy", 102, {29'd0, rd_busy}, 32'h0);
    chk("rst_cnt", 102, {26'd0, pend_cnt}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_r10", 103, rd_data[31:0], 32'h0);
    chk("post_rst_busy_r1", 103, {31'd0, rd_busy[1]}, 32'd0);
    chk("post_rst_cnt", 103, {26'd0, pend_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
